// File: rtl/rom_dl_writer.sv
// rom_dl_writer: turns an ioctl byte download into 16-bit SDRAM writes on a toggle req/ack port.
// Latency: a completing byte strobe at cycle N with an empty FIFO and idle port toggles port_req at cycle N+2.
// Backpressure: ioctl_wait rises while the word FIFO might not absorb the next push; a lost push sets sticky overflow.
// Build option: define DL_PACK_EN to merge the two byte lanes of one word into a single write.
module rom_dl_writer #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [23:0] BASE       = 24'h000000
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        port_req,
   input  logic        port_ack,
   output logic        port_we,
   output logic [22:0] port_a,
   output logic [1:0]  port_ds,
   output logic [15:0] port_d,
   output logic        done,
   output logic        overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } entry_t;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Incoming byte decode
   // ------------------------------------------------------------------
   logic        wr_en;
   logic [23:0] addr_sum;
   logic [22:0] wa;
   logic        lane;
   logic        unused_addr_carry;

   assign wr_en    = ioctl_wr & ioctl_downl;
   assign addr_sum = ioctl_addr[24:1] + BASE;
   assign wa       = addr_sum[22:0];
   // The word address wraps modulo 2^23, so the top sum bit is dropped.
   assign unused_addr_carry = addr_sum[23];
   assign lane     = ioctl_addr[0];

   assign port_we = 1'b1;

   // ------------------------------------------------------------------
   // Word FIFO
   // ------------------------------------------------------------------
   entry_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   entry_t        push_dat;
   entry_t        head;
   logic          pend_busy;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign free  = DEPTH_C - count;
   assign head  = mem[rd_ptr];
   // A pop on a full FIFO frees the slot the push lands in during the same edge.
   assign push_ok = push_req & (~full | pop);

   // FIFO storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky flag for any entry dropped at a full FIFO
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         overflow <= 1'b0;
      end else if (push_req && full && !pop) begin
         overflow <= 1'b1;
      end
   end

`ifdef DL_PACK_EN
   // ------------------------------------------------------------------
   // Half-word packer: holds one byte until its partner lane arrives
   // ------------------------------------------------------------------
   logic        pend_vld;
   logic [22:0] pend_a;
   logic        pend_lane;
   logic [7:0]  pend_b;
   logic        hit;
   logic        merge;
   logic        same;

   assign hit   = pend_vld && (wa == pend_a);
   assign merge = wr_en && hit && (lane != pend_lane);
   assign same  = wr_en && hit && (lane == pend_lane);
   assign pend_busy = pend_vld;

   // Decide what, if anything, the packer pushes this cycle
   always_comb begin
      push_req    = 1'b0;
      push_dat.a  = pend_a;
      push_dat.ds = pend_lane ? 2'b10 : 2'b01;
      push_dat.d  = {pend_b, pend_b};
      if (merge) begin
         push_req    = 1'b1;
         push_dat.ds = 2'b11;
         push_dat.d  = lane ? {ioctl_dout, pend_b} : {pend_b, ioctl_dout};
      end else if (wr_en && pend_vld && !same) begin
         // unrelated byte evicts the pending half-word as a single-lane write
         push_req = 1'b1;
      end else if (!ioctl_downl && pend_vld) begin
         // download ended with a lone byte still waiting for its partner
         push_req = 1'b1;
      end
   end

   // Pending half-word register
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         pend_vld  <= 1'b0;
         pend_a    <= '0;
         pend_lane <= 1'b0;
         pend_b    <= '0;
      end else if (merge) begin
         pend_vld <= 1'b0;
      end else if (wr_en) begin
         pend_vld  <= 1'b1;
         pend_a    <= wa;
         pend_lane <= lane;
         pend_b    <= ioctl_dout;
      end else if (!ioctl_downl) begin
         pend_vld <= 1'b0;
      end
   end

   // Reserve an extra slot while a half-word might be evicted alongside a push
   assign ioctl_wait = (free <= CW'(1)) || (pend_vld && (free <= CW'(2)));
`else
   assign pend_busy = 1'b0;

   // Every accepted byte becomes its own single-lane write
   always_comb begin
      push_req    = wr_en;
      push_dat.a  = wa;
      push_dat.ds = lane ? 2'b10 : 2'b01;
      push_dat.d  = {ioctl_dout, ioctl_dout};
   end

   assign ioctl_wait = (free <= CW'(1));
`endif

   // ------------------------------------------------------------------
   // Issue FSM: one outstanding toggle request at a time
   // ------------------------------------------------------------------
   state_t state;
   state_t state_nxt;

   // State register
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: leave WAIT_ACK only once the controller echoes the toggle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!empty) state_nxt = WAIT_ACK;
         WAIT_ACK: if (port_ack == port_req) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output decode: pop the FIFO head only from IDLE
   always_comb begin
      pop = (state == IDLE) && !empty;
   end

   // Request port registers, held stable for the whole WAIT_ACK
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         port_req <= 1'b0;
         port_a   <= '0;
         port_ds  <= '0;
         port_d   <= '0;
      end else if (pop) begin
         port_req <= ~port_req;
         port_a   <= head.a;
         port_ds  <= head.ds;
         port_d   <= head.d;
      end
   end

   // ------------------------------------------------------------------
   // Completion pulse, once per download after everything has drained
   // ------------------------------------------------------------------
   logic dl_seen;

   // A fresh download re-arms the pulse and defers it until its own end
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         dl_seen <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (ioctl_downl) begin
            dl_seen <= 1'b1;
         end else if (dl_seen && !pend_busy && empty && (state == IDLE)) begin
            done    <= 1'b1;
            dl_seen <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_writer.sv
// Bench for rom_dl_writer: scoreboard of expected SDRAM writes checked by a controller model.
// Stimulus and sampling happen on the falling clock edge; the DUT registers on the rising edge.
// Expectations follow the default build unless DL_PACK_EN is defined for both files.
module tb_rom_dl_writer;

   localparam logic [23:0] TB_BASE = 24'h000100;

   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } exp_t;

   logic        clk;
   logic        init_n;
   logic        ioctl_downl;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        port_req;
   logic        port_ack;
   logic        port_we;
   logic [22:0] port_a;
   logic [1:0]  port_ds;
   logic [15:0] port_d;
   logic        done;
   logic        overflow;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   int   ack_delay = 0;
   bit   sb_en     = 1;
   bit   mon_busy  = 0;
   logic mon_req   = 0;
   int   mon_cnt   = 0;
   logic [22:0] cap_a;
   logic [1:0]  cap_ds;
   logic [15:0] cap_d;

   rom_dl_writer #(
      .FIFO_DEPTH (4),
      .BASE       (TB_BASE)
   ) dut (
      .clk         (clk),
      .init_n      (init_n),
      .ioctl_downl (ioctl_downl),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .ioctl_wait  (ioctl_wait),
      .port_req    (port_req),
      .port_ack    (port_ack),
      .port_we     (port_we),
      .port_a      (port_a),
      .port_ds     (port_ds),
      .port_d      (port_d),
      .done        (done),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SDRAM controller model: checks each new request against the scoreboard, acks after ack_delay
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] mask;
      if (!init_n) begin
         port_ack = 1'b0;
         mon_busy = 1'b0;
         mon_req  = 1'b0;
      end else if (port_req !== mon_req) begin
         mon_req  = port_req;
         mon_busy = 1'b1;
         mon_cnt  = ack_delay;
         cap_a    = port_a;
         cap_ds   = port_ds;
         cap_d    = port_d;
         if (sb_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: got write a=%h ds=%b d=%h, expected no write", port_a, port_ds, port_d);
            end else begin
               e    = exp_q.pop_front();
               mask = {{8{e.ds[1]}}, {8{e.ds[0]}}};
               if (port_a !== e.a || port_ds !== e.ds || (port_d & mask) !== (e.d & mask)) begin
                  bad++;
                  $display("FAIL sb_write: got a=%h ds=%b d=%h, expected a=%h ds=%b d=%h",
                           port_a, port_ds, port_d, e.a, e.ds, e.d);
               end
            end
         end
      end else if (mon_busy) begin
         if (mon_cnt == 0) begin
            total++;
            if ({port_a, port_ds, port_d} !== {cap_a, cap_ds, cap_d}) begin
               bad++;
               $display("FAIL hold: got a=%h ds=%b d=%h, expected a=%h ds=%b d=%h",
                        port_a, port_ds, port_d, cap_a, cap_ds, cap_d);
            end
            port_ack = port_req;
            mon_busy = 1'b0;
         end else begin
            mon_cnt--;
         end
      end
   end

   // One-cycle byte strobe, entered and left on a falling edge
   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
   endtask

   task automatic test_reset();
      init_n = 1'b1;
      #3 init_n = 1'b0;
      @(negedge clk);
      total++; if (port_req !== 1'b0)  begin bad++; $display("FAIL rst_req: got %b, expected 0", port_req); end
      total++; if (port_a !== 23'd0)   begin bad++; $display("FAIL rst_a: got %h, expected 0", port_a); end
      total++; if (port_d !== 16'd0)   begin bad++; $display("FAIL rst_d: got %h, expected 0", port_d); end
      total++; if (port_ds !== 2'b00)  begin bad++; $display("FAIL rst_ds: got %b, expected 00", port_ds); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b, expected 0", done); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_ovf: got %b, expected 0", overflow); end
      total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait: got %b, expected 0", ioctl_wait); end
      total++; if (port_we !== 1'b1)   begin bad++; $display("FAIL rst_we: got %b, expected 1", port_we); end
      @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pair();
      logic r0;
      bit   tog;
      int   ndone;
      ack_delay   = 0;
      ioctl_downl = 1'b1;
`ifdef DL_PACK_EN
      exp_q.push_back({TB_BASE[22:0], 2'b11, 16'h2211});
`else
      exp_q.push_back({TB_BASE[22:0], 2'b01, 16'h1111});
      exp_q.push_back({TB_BASE[22:0], 2'b10, 16'h2222});
`endif
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         r0 = port_req;
`ifdef DL_PACK_EN
         tog = (i == 1);
`else
         tog = 1'b1;
`endif
         strobe(25'(i), (i == 0) ? 8'h11 : 8'h22);
         total++;
         if (port_req !== r0) begin
            bad++; $display("FAIL pair_lat_n1[%0d]: got req=%b, expected %b", i, port_req, r0);
         end
         @(negedge clk);
         total++;
         if (port_req !== (tog ? ~r0 : r0)) begin
            bad++; $display("FAIL pair_lat_n2[%0d]: got req=%b, expected %b", i, port_req, tog ? ~r0 : r0);
         end
         repeat (4) @(negedge clk);
      end
      ioctl_downl = 1'b0;
      ndone = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL pair_done: got %0d pulses, expected 1", ndone); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL pair_left: got %0d unwritten, expected 0", exp_q.size()); end
   endtask

   task automatic test_single();
      int ndone;
      bit early;
      ack_delay   = 3;
      ioctl_downl = 1'b1;
      exp_q.push_back({23'(TB_BASE + 24'd2), 2'b10, 16'hAB00});
      @(negedge clk);
      strobe(25'd5, 8'hAB);
      @(negedge clk);
      ioctl_downl = 1'b0;
      ndone = 0;
      early = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (mon_busy || exp_q.size() != 0) early = 1'b1;
         end
      end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL single_done: got %0d pulses, expected 1", ndone); end
      total++;
      if (early) begin bad++; $display("FAIL single_done_early: got done before ack, expected after"); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL single_left: got %0d unwritten, expected 0", exp_q.size()); end
   endtask

   task automatic test_wrap_ignore();
      int   ndone;
      logic r0;
      ack_delay   = 0;
      ioctl_downl = 1'b1;
      // word 0xFFFFFF + 0x100 wraps to 0x0000FF in 23 bits
      exp_q.push_back({23'h0000FF, 2'b01, 16'h005A});
      @(negedge clk);
      strobe(25'h1FFFFFE, 8'h5A);
      @(negedge clk);
      ioctl_downl = 1'b0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      total++;
      if (ndone != 1 || exp_q.size() != 0) begin
         bad++; $display("FAIL wrap_done: got %0d pulses %0d left, expected 1 pulse 0 left", ndone, exp_q.size());
      end
      r0 = port_req;
      strobe(25'd0, 8'hEE);
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      total++;
      if (port_req !== r0 || ndone != 0) begin
         bad++; $display("FAIL ignore_wr: got req=%b done=%0d, expected req=%b done=0", port_req, ndone, r0);
      end
   endtask

   task automatic test_backpressure();
      int   sent;
      int   cyc;
      int   ndone;
      bit   saw_wait;
      logic [7:0]  d;
      logic [7:0]  dprev;
      logic [22:0] a;
      ack_delay   = 50;
      ioctl_downl = 1'b1;
      sent = 0; cyc = 0; saw_wait = 1'b0; dprev = 8'h00;
      @(negedge clk);
      while (sent < 16 && cyc < 3000) begin
         ioctl_wr = 1'b0;
         if (ioctl_wait === 1'b1) begin
            saw_wait = 1'b1;
         end else begin
            d = 8'h30 + 8'(sent);
            a = 23'(TB_BASE + 24'h20 + 24'(sent / 2));
            ioctl_addr = 25'h40 + 25'(sent);
            ioctl_dout = d;
            ioctl_wr   = 1'b1;
`ifdef DL_PACK_EN
            if (sent % 2 == 1) exp_q.push_back({a, 2'b11, d, dprev});
`else
            exp_q.push_back({a, (sent % 2 == 1) ? 2'b10 : 2'b01, d, d});
`endif
            dprev = d;
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      ioctl_wr = 1'b0;
      total++;
      if (sent != 16) begin bad++; $display("FAIL bp_timeout: got %0d bytes sent, expected 16", sent); end
      total++;
      if (!saw_wait) begin bad++; $display("FAIL bp_wait: got ioctl_wait never high, expected high"); end
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf: got %b, expected 0", overflow); end
      ioctl_downl = 1'b0;
      ndone = 0;
      for (int c = 0; c < 2000 && ndone == 0; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      total++;
      if (ndone != 1 || exp_q.size() != 0) begin
         bad++; $display("FAIL bp_drain: got %0d pulses %0d left, expected 1 pulse 0 left", ndone, exp_q.size());
      end
   endtask

   task automatic test_overflow();
      ack_delay   = 200;
      sb_en       = 1'b0;
      ioctl_downl = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         ioctl_addr = 25'h80 + 25'(i);
         ioctl_dout = 8'(i);
         ioctl_wr   = 1'b1;
         @(negedge clk);
      end
      ioctl_wr = 1'b0;
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, expected 1", overflow); end
      ioctl_downl = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
      init_n = 1'b0;
      #1;
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
      @(negedge clk);
      @(negedge clk);
      init_n = 1'b1;
      sb_en  = 1'b1;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset_waitack();
      int   ndone;
      bit   moved;
      ack_delay   = 100;
      ioctl_downl = 1'b1;
`ifdef DL_PACK_EN
      exp_q.push_back({23'(TB_BASE + 24'h8), 2'b11, 16'h8877});
`else
      exp_q.push_back({23'(TB_BASE + 24'h8), 2'b01, 16'h7777});
      exp_q.push_back({23'(TB_BASE + 24'h8), 2'b10, 16'h8888});
`endif
      @(negedge clk);
      strobe(25'h10, 8'h77);
      strobe(25'h11, 8'h88);
      repeat (4) @(negedge clk);
      total++;
      if (port_req !== 1'b1) begin bad++; $display("FAIL wa_issued: got req=%b, expected 1", port_req); end
      init_n = 1'b0;
      #1;
      total++;
      if ({port_req, port_a, port_d, port_ds, done, overflow, ioctl_wait} !== 45'd0 || port_we !== 1'b1) begin
         bad++;
         $display("FAIL wa_reset: got req=%b a=%h d=%h ds=%b done=%b ovf=%b wait=%b we=%b, expected all 0 and we=1",
                  port_req, port_a, port_d, port_ds, done, overflow, ioctl_wait, port_we);
      end
      ioctl_downl = 1'b0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      init_n = 1'b1;
      moved = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (port_req !== 1'b0) moved = 1'b1;
         if (done === 1'b1) ndone++;
      end
      total++;
      if (moved || ndone != 0) begin
         bad++; $display("FAIL wa_quiet: got req_moved=%b done=%0d, expected 0 and 0", moved, ndone);
      end
   endtask

   initial begin
      init_n      = 1'b1;
      ioctl_downl = 1'b0;
      ioctl_wr    = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      test_reset();
      test_pair();
      test_single();
      test_wrap_ignore();
      test_backpressure();
      test_overflow();
      test_reset_waitack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
